// File: rtl/cpu_loader_pkg.sv
// Shared types and default sizes for the byte-serial program loader and its word FIFO.
package cpu_loader_pkg;

   localparam int WORD_W_DEF     = 16;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int ADDR_W_DEF     = 8;

   // ST_CHECK is only reachable when the checksum byte is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_LO    = 3'd2,
      ST_HI    = 3'd3,
      ST_CHECK = 3'd4,
      ST_DRAIN = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [WORD_W_DEF-1:0] word;
   } fifo_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous word FIFO with a registered head entry; a push onto a full FIFO
// is accepted only when the head is popped in the same cycle.
module loader_fifo
   import cpu_loader_pkg::*;
#(
   parameter int  DEPTH   = FIFO_DEPTH_DEF,
   parameter type entry_t = fifo_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop_req,
   output logic   push_ok,
   output logic   empty_next,
   output entry_t head,
   output logic   valid
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   entry_t            head_q, head_d;
   logic              full;
   logic              pop_ok;

   always_comb begin
      full    = (cnt_q == CNT_W'(DEPTH));
      pop_ok  = pop_req && (cnt_q != '0);
      push_ok = push && (!full || pop_ok);

      rd_d = pop_ok  ? rd_q + PTR_W'(1) : rd_q;
      wr_d = push_ok ? wr_q + PTR_W'(1) : wr_q;

      cnt_d = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      // The head register is refilled either straight from the incoming word (FIFO
      // about to hold only that word) or from the entry behind the one being popped.
      head_d = head_q;
      if (push_ok && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop_ok))) begin
         head_d = push_data;
      end else if (pop_ok && (cnt_q > CNT_W'(1))) begin
         head_d = mem[rd_q + PTR_W'(1)];
      end

      empty_next = (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   assign head  = head_q;
   assign valid = (cnt_q != '0);

endmodule

// File: rtl/cpu_prog_loader.sv
// Byte-serial program loader: length-prefixed byte stream -> 16-bit words -> FIFO -> core.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the checksum_ok output.
module cpu_prog_loader
   import cpu_loader_pkg::*;
#(
   parameter int WORD_W     = WORD_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_stb,
   output logic [WORD_W-1:0] word_out,
   output logic [ADDR_W-1:0] word_addr,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic              checksum_ok
`endif
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] word;
   } entry_t;

   state_t            state_q, state_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        rem_q, rem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
   logic              ok_q, ok_d;
`endif

   logic              push;
   entry_t            push_data;
   entry_t            head;
   logic              push_ok;
   logic              empty_next;
   logic              fifo_valid;

   always_comb begin
      push_data.addr = addr_q;
      push_data.word = WORD_W'({byte_in, lo_q});
   end

   loader_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (push_data),
      .pop_req    (word_ready),
      .push_ok    (push_ok),
      .empty_next (empty_next),
      .head       (head),
      .valid      (fifo_valid)
   );

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      ovf_d   = ovf_q;
      push    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      ok_d    = ok_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LEN;
               addr_d  = '0;
               ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = '0;
               ok_d    = 1'b0;
`endif
            end
         end
         ST_LEN: begin
            if (byte_stb) begin
               if (byte_in == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  rem_d   = byte_in;
                  state_d = ST_LO;
               end
            end
         end
         ST_LO: begin
            if (byte_stb) begin
               lo_d    = byte_in;
               state_d = ST_HI;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ byte_in;
`endif
            end
         end
         ST_HI: begin
            if (byte_stb) begin
               push   = 1'b1;
               // A dropped word still consumes its address slot and its count.
               if (!push_ok) begin
                  ovf_d = 1'b1;
               end
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - 8'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_in;
               state_d = (rem_q == 8'd1) ? ST_CHECK : ST_LO;
`else
               state_d = (rem_q == 8'd1) ? ST_DRAIN : ST_LO;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (byte_stb) begin
               ok_d    = (byte_in == csum_q);
               state_d = ST_DRAIN;
            end
         end
`endif
         ST_DRAIN: begin
            // Look one cycle ahead so the last pop and the DONE entry coincide.
            if (empty_next) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lo_q    <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
         ok_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
         ok_q    <= ok_d;
`endif
      end
   end

   assign word_out   = head.word;
   assign word_addr  = head.addr;
   assign word_valid = fifo_valid;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum_ok = ok_q;
`endif

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader; expected words go through a scoreboard queue.
module tb_cpu_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_stb;
   logic [15:0] word_out;
   logic [7:0]  word_addr;
   logic        word_valid;
   logic        word_ready;
   logic        busy;
   logic        done;
   logic        overflow;
`ifdef LOADER_CHECKSUM_EN
   logic        checksum_ok;
`endif

   logic [23:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   cpu_prog_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .byte_stb   (byte_stb),
      .word_out   (word_out),
      .word_addr  (word_addr),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum_ok(checksum_ok)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: score a handshake that fires on the coming edge, then advance.
   task automatic step();
      logic [23:0] exp;
      if (word_valid && word_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            $display("pop addr=%02h word=%04h exp_addr=%02h exp_word=%04h",
                     word_addr, word_out, exp[23:16], exp[15:0]);
            chk("pop_word", {8'h00, word_addr, word_out}, {8'h00, exp});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in  = b;
      byte_stb = 1'b1;
      step();
      byte_stb = 1'b0;
      byte_in  = 8'h00;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_word(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] addr, input bit accept);
      send_byte(lo);
      if (accept) sb.push_back({addr, hi, lo});
      send_byte(hi);
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n = 0;
      while (!done && n < bound) begin
         step();
         n++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_word_out"},  32'(word_out),   32'd0);
      chk({tag, "_word_addr"}, 32'(word_addr),  32'd0);
      chk({tag, "_valid"},     32'(word_valid), 32'd0);
      chk({tag, "_busy"},      32'(busy),       32'd0);
      chk({tag, "_done"},      32'(done),       32'd0);
      chk({tag, "_overflow"},  32'(overflow),   32'd0);
`ifdef LOADER_CHECKSUM_EN
      chk({tag, "_cks_ok"},    32'(checksum_ok), 32'd0);
`endif
   endtask

   initial begin
      logic [7:0] lo, hi, cs;

      rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_stb = 1'b0; word_ready = 1'b0;
      repeat (3) step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();

      // N=2 stream 02 34 12 78 56 with the core always ready
      word_ready = 1'b1;
      chk("t1_idle_busy", 32'(busy), 32'd0);
      pulse_start();
      chk("t1_busy_rise", 32'(busy), 32'd1);
      send_byte(8'h02);
      load_word(8'h34, 8'h12, 8'h00, 1'b1);
      chk("t1_latency_valid", 32'(word_valid), 32'd1);
      load_word(8'h78, 8'h56, 8'h01, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56);
`endif
      wait_done("t1_done", 20);
      chk("t1_overflow", 32'(overflow), 32'd0);
      step();
      chk("t1_done_one_cycle", 32'(done), 32'd0);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);

      // N=0: done right after the length strobe, nothing delivered
      pulse_start();
      send_byte(8'h00);
      chk("n0_done", 32'(done), 32'd1);
      chk("n0_valid", 32'(word_valid), 32'd0);
      step();
      chk("n0_idle", 32'(busy), 32'd0);

      // N=6 with the core stalled: four words held, two dropped
      word_ready = 1'b0;
      pulse_start();
      send_byte(8'h06);
      cs = 8'h00;
      for (int i = 0; i < 6; i++) begin
         lo = 8'(8'h10 + i);
         hi = 8'(8'hA0 + i);
         cs = cs ^ lo ^ hi;
         load_word(lo, hi, 8'(i), i < 4);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs);
`endif
      repeat (3) step();
      chk("t3_overflow", 32'(overflow), 32'd1);
      chk("t3_no_done", 32'(done), 32'd0);
      chk("t3_busy_drain", 32'(busy), 32'd1);
      chk("t3_head", {8'h00, word_addr, word_out}, 32'h0000A010);
      // stray start and strobe while draining must be ignored
      start = 1'b1; byte_in = 8'hEE; byte_stb = 1'b1;
      step();
      start = 1'b0; byte_stb = 1'b0; byte_in = 8'h00;
      word_ready = 1'b1;
      wait_done("t3_done", 20);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);
      step();
      step();
      chk("t3_overflow_sticky", 32'(overflow), 32'd1);
      chk("t3_idle", 32'(busy), 32'd0);

      // N=5: fill the FIFO, then push and pop in the same cycle
      word_ready = 1'b0;
      pulse_start();
      chk("t4_overflow_cleared", 32'(overflow), 32'd0);
      send_byte(8'h05);
      cs = 8'h00;
      for (int i = 0; i < 4; i++) begin
         lo = 8'(8'h40 + i);
         hi = 8'(8'hC0 + i);
         cs = cs ^ lo ^ hi;
         load_word(lo, hi, 8'(i), 1'b1);
      end
      chk("t4_full_head", {8'h00, word_addr, word_out}, 32'h0000C040);
      send_byte(8'h44);
      word_ready = 1'b1;
      sb.push_back({8'h04, 8'hC4, 8'h44});
      send_byte(8'hC4);
      cs = cs ^ 8'h44 ^ 8'hC4;
      chk("t4_no_overflow", 32'(overflow), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs);
`endif
      wait_done("t4_done", 20);
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);
      chk("t4_overflow_final", 32'(overflow), 32'd0);
      step();

      // reset after the low byte of the second word, with one word still queued
      word_ready = 1'b0;
      pulse_start();
      send_byte(8'h02);
      load_word(8'h34, 8'h12, 8'h00, 1'b1);
      send_byte(8'h99);
      chk("t5_pre_reset_valid", 32'(word_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      chk_reset_outputs("t5_mid_reset");
      step();

      // minimum load after reset, starting again at address 0
      word_ready = 1'b1;
      pulse_start();
      send_byte(8'h01);
      sb.push_back({8'h00, 8'hAB, 8'hCD});
      send_byte(8'hCD);
      send_byte(8'hAB);
`ifndef LOADER_CHECKSUM_EN
      chk("t6_valid", 32'(word_valid), 32'd1);
      chk("t6_not_done_yet", 32'(done), 32'd0);
      step();
      chk("t6_min_done", 32'(done), 32'd1);
`else
      send_byte(8'hCD ^ 8'hAB);
      wait_done("t6_done", 20);
      chk("t6_cks_ok", 32'(checksum_ok), 32'd1);
`endif
      step();
      chk("t6_idle", 32'(busy), 32'd0);
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // checksum byte FF matches AA^55, 00 does not; the word is delivered either way
      pulse_start();
      send_byte(8'h01);
      load_word(8'hAA, 8'h55, 8'h00, 1'b1);
      send_byte(8'hFF);
      wait_done("t7_done", 20);
      chk("t7_cks_ok", 32'(checksum_ok), 32'd1);
      step();
      chk("t7_cks_hold", 32'(checksum_ok), 32'd1);
      pulse_start();
      chk("t7_cks_cleared_on_start", 32'(checksum_ok), 32'd0);
      send_byte(8'h01);
      load_word(8'hAA, 8'h55, 8'h00, 1'b1);
      send_byte(8'h00);
      wait_done("t8_done", 20);
      chk("t8_cks_bad", 32'(checksum_ok), 32'd0);
      chk("t8_sb_empty", 32'(sb.size()), 32'd0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
